// File: rtl/ad9911_pkg.sv
// Shared definitions for the AD9911 serial register writer: state encoding,
// instruction-byte prefix, maximum legal address and the register-width table.
package ad9911_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_UPDATE,
        ST_ERRDONE
    } state_t;

    // Upper three bits of the instruction byte: write (R/W=0), two reserved zeros.
    localparam logic [2:0] INSTR_PREFIX = 3'b000;
    localparam logic [7:0] MAX_ADDR     = 8'h18;

    function automatic logic [5:0] addr_width(input logic [7:0] addr);
        logic [5:0] w;
        case (addr)
            8'h00:               w = 6'd8;
            8'h02, 8'h05, 8'h07: w = 6'd16;
            8'h01, 8'h03, 8'h06: w = 6'd24;
            default:             w = 6'd32;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ad9911_serial_tx.sv
// Writes one AD9911 register per TR rising edge: CS_N/SCLK/SDIO frame then IO_UPDATE pulse.
// OVER rises (2N+1)*CLK_DIV+UPD_WIDTH cycles after accept; TR edges while BUSY are dropped.
module ad9911_serial_tx
    import ad9911_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int UPD_WIDTH = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        TR,
    input  logic [7:0]  ADDR,
    input  logic [31:0] DATA,
    output logic        OVER,
    output logic        ERR,
    output logic        BUSY,
    output logic        CS_N,
    output logic        SCLK,
    output logic        SDIO,
    output logic        IO_UPDATE
);

    localparam logic [15:0] TICK_MAX = 16'(CLK_DIV - 1);
    localparam logic [15:0] UPD_MAX  = 16'((UPD_WIDTH > 0) ? UPD_WIDTH - 1 : 0);

    state_t      state, nxt_state;
    logic        tr_d;
    logic [15:0] tick_cnt, nxt_tick_cnt;
    logic [15:0] upd_cnt, nxt_upd_cnt;
    logic [5:0]  bit_cnt, nxt_bit_cnt;
    logic [39:0] shreg, nxt_shreg;
    logic        nxt_over, nxt_err, nxt_cs_n, nxt_sclk, nxt_sdio, nxt_io_update;
    logic        tick;
    logic [5:0]  width;

    assign tick  = (tick_cnt == TICK_MAX);
    assign width = addr_width(ADDR);
    assign BUSY  = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            tr_d      <= 1'b1;
            tick_cnt  <= '0;
            upd_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            OVER      <= 1'b0;
            ERR       <= 1'b0;
            CS_N      <= 1'b1;
            SCLK      <= 1'b0;
            SDIO      <= 1'b0;
            IO_UPDATE <= 1'b0;
        end else begin
            state     <= nxt_state;
            tr_d      <= TR;
            tick_cnt  <= nxt_tick_cnt;
            upd_cnt   <= nxt_upd_cnt;
            bit_cnt   <= nxt_bit_cnt;
            shreg     <= nxt_shreg;
            OVER      <= nxt_over;
            ERR       <= nxt_err;
            CS_N      <= nxt_cs_n;
            SCLK      <= nxt_sclk;
            SDIO      <= nxt_sdio;
            IO_UPDATE <= nxt_io_update;
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_tick_cnt  = (state == ST_IDLE || tick) ? 16'd0 : tick_cnt + 16'd1;
        nxt_upd_cnt   = upd_cnt;
        nxt_bit_cnt   = bit_cnt;
        nxt_shreg     = shreg;
        nxt_over      = OVER;
        nxt_err       = ERR;
        nxt_cs_n      = CS_N;
        nxt_sclk      = SCLK;
        nxt_sdio      = SDIO;
        nxt_io_update = IO_UPDATE;

        case (state)
            ST_IDLE: begin
                if (TR && !tr_d) begin
                    nxt_over     = 1'b0;
                    nxt_err      = 1'b0;
                    nxt_tick_cnt = 16'd0;
                    if (ADDR > MAX_ADDR) begin
                        nxt_state = ST_ERRDONE;
                    end else begin
                        // Payload is left-aligned behind the instruction byte so bit 39 is always next out.
                        nxt_state   = ST_SETUP;
                        nxt_shreg   = {INSTR_PREFIX, ADDR[4:0], DATA << (6'd32 - width)};
                        nxt_bit_cnt = width + 6'd7;
                        nxt_cs_n    = 1'b0;
                        nxt_sdio    = INSTR_PREFIX[2];
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    nxt_sclk  = 1'b1;
                    nxt_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (SCLK) begin
                        nxt_sclk = 1'b0;
                        if (bit_cnt == 6'd0) begin
                            nxt_state = ST_HOLD;
                        end else begin
                            nxt_sdio    = shreg[38];
                            nxt_shreg   = {shreg[38:0], 1'b0};
                            nxt_bit_cnt = bit_cnt - 6'd1;
                        end
                    end else begin
                        nxt_sclk = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    nxt_cs_n = 1'b1;
                    nxt_sdio = 1'b0;
                    if (UPD_WIDTH > 0) begin
                        nxt_state     = ST_UPDATE;
                        nxt_io_update = 1'b1;
                        nxt_upd_cnt   = 16'd0;
                    end else begin
                        nxt_state = ST_IDLE;
                        nxt_over  = 1'b1;
                    end
                end
            end
            ST_UPDATE: begin
                if (upd_cnt == UPD_MAX) begin
                    nxt_io_update = 1'b0;
                    nxt_over      = 1'b1;
                    nxt_state     = ST_IDLE;
                end else begin
                    nxt_upd_cnt = upd_cnt + 16'd1;
                end
            end
            ST_ERRDONE: begin
                nxt_over  = 1'b1;
                nxt_err   = 1'b1;
                nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ad9911_serial_tx.sv
// Directed bench for ad9911_serial_tx with default parameters (CLK_DIV=2, UPD_WIDTH=4).
module tb_ad9911_serial_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        over, err, busy, cs_n, sclk, sdio, io_update;

    int checks = 0;
    int fails  = 0;

    ad9911_serial_tx dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .TR        (tr),
        .ADDR      (addr),
        .DATA      (data),
        .OVER      (over),
        .ERR       (err),
        .BUSY      (busy),
        .CS_N      (cs_n),
        .SCLK      (sclk),
        .SDIO      (sdio),
        .IO_UPDATE (io_update)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // One full write; checks bit content, CS_N/IO_UPDATE/OVER timing and flag states.
    task automatic run_frame(input logic [7:0] a, input logic [31:0] dv, input int w,
                             input bit mutate, input bit retrig, input string nm);
        logic [39:0] exp_f, got;
        int n, nbits, cs_rise, iu_first, iu_cnt, over_k, t_end;
        logic psclk;
        n = 8 + w;
        t_end = (2 * n + 1) * 2;
        exp_f = {3'b000, a[4:0], 32'h0};
        exp_f[31:0] = dv << (32 - w);
        @(negedge clk);
        tr = 1'b1; addr = a; data = dv;
        @(posedge clk); #1;
        checks++; if (cs_n !== 1'b0) begin fails++; $display("FAIL %s e0 cs_n: got %b want 0", nm, cs_n); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL %s e0 busy: got %b want 1", nm, busy); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL %s e0 err: got %b want 0", nm, err); end
        checks++; if (sdio !== exp_f[39]) begin fails++; $display("FAIL %s e0 sdio: got %b want %b", nm, sdio, exp_f[39]); end
        got = '0; nbits = 0; cs_rise = -1; iu_first = -1; iu_cnt = 0; over_k = -1; psclk = sclk;
        for (int k = 1; k <= 400 && over_k < 0; k++) begin
            if (k == 2) tr = 1'b0;
            if (mutate && k == 3) begin data = ~dv; addr = 8'h01; end
            if (retrig && k == 50) tr = 1'b1;
            if (retrig && k == 52) tr = 1'b0;
            @(posedge clk); #1;
            if (k == 1) begin
                checks++; if (over !== 1'b0) begin fails++; $display("FAIL %s over_e0p1: got %b want 0", nm, over); end
            end
            if (sclk && !psclk) begin got = {got[38:0], sdio}; nbits++; end
            psclk = sclk;
            if (cs_n && cs_rise < 0) cs_rise = k;
            if (io_update) begin if (iu_first < 0) iu_first = k; iu_cnt++; end
            if (over === 1'b1) over_k = k;
        end
        checks++; if (over_k != t_end + 4) begin fails++; $display("FAIL %s over_time: got %0d want %0d", nm, over_k, t_end + 4); end
        checks++; if (nbits != n) begin fails++; $display("FAIL %s bit_count: got %0d want %0d", nm, nbits, n); end
        checks++; if ((got << (40 - n)) !== exp_f) begin fails++; $display("FAIL %s bits: got %h want %h", nm, got << (40 - n), exp_f); end
        checks++; if (cs_rise != t_end) begin fails++; $display("FAIL %s cs_rise: got %0d want %0d", nm, cs_rise, t_end); end
        checks++; if (iu_first != t_end) begin fails++; $display("FAIL %s io_update_start: got %0d want %0d", nm, iu_first, t_end); end
        checks++; if (iu_cnt != 4) begin fails++; $display("FAIL %s io_update_width: got %0d want 4", nm, iu_cnt); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL %s end busy/err: got %b%b want 00", nm, busy, err); end
    endtask

    task automatic test_reset();
        int lows;
        rst_n = 1'b0; tr = 1'b1; addr = 8'h00; data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({cs_n, sclk, sdio, io_update} !== 4'b1000) begin fails++; $display("FAIL reset pins: got %b want 1000", {cs_n, sclk, sdio, io_update}); end
        checks++; if ({over, err, busy} !== 3'b000) begin fails++; $display("FAIL reset flags: got %b want 000", {over, err, busy}); end
        @(negedge clk); rst_n = 1'b1;
        lows = 0;
        repeat (6) begin @(posedge clk); #1; if (cs_n !== 1'b1 || busy !== 1'b0) lows++; end
        checks++; if (lows != 0) begin fails++; $display("FAIL reset_tr_held: got %0d active cycles want 0", lows); end
        @(negedge clk); tr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_frame(8'h00, 32'h0000_0020, 8, 1'b0, 1'b0, "addr00");
    endtask

    task automatic test_wide_mutate();
        run_frame(8'h04, 32'h0111_1111, 32, 1'b1, 1'b0, "addr04");
    endtask

    task automatic test_sequence();
        int wtab [11] = '{8, 24, 16, 24, 32, 16, 24, 16, 32, 32, 32};
        for (int i = 0; i < 11; i++)
            run_frame(8'(i), 32'hA5C3_5A3C ^ (32'(i) * 32'h0101_0101), wtab[i], 1'b0, 1'b0, "seq");
    endtask

    task automatic test_error();
        int act;
        @(negedge clk);
        tr = 1'b1; addr = 8'h1F; data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        checks++; if ({over, err, busy, cs_n} !== 4'b0011) begin fails++; $display("FAIL err_e0: got %b want 0011", {over, err, busy, cs_n}); end
        @(negedge clk); tr = 1'b0;
        @(posedge clk); #1;
        checks++; if ({over, err, busy} !== 3'b110) begin fails++; $display("FAIL err_e0p1: got %b want 110", {over, err, busy}); end
        act = 0;
        repeat (5) begin @(posedge clk); #1; if (!cs_n || sclk || io_update || !err) act++; end
        checks++; if (act != 0) begin fails++; $display("FAIL err_quiet: got %0d bad cycles want 0", act); end
        run_frame(8'h02, 32'h0000_BEEF, 16, 1'b0, 1'b0, "after_err");
    endtask

    task automatic test_reset_midframe();
        int act;
        @(negedge clk);
        tr = 1'b1; addr = 8'h09; data = 32'h1234_5678;
        @(posedge clk);
        repeat (40) @(posedge clk);
        #1;
        checks++; if (cs_n !== 1'b0) begin fails++; $display("FAIL midframe_active cs_n: got %b want 0", cs_n); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({cs_n, sclk, sdio, io_update, over, err, busy} !== 7'b1000000) begin
            fails++; $display("FAIL midframe_reset: got %b want 1000000", {cs_n, sclk, sdio, io_update, over, err, busy}); end
        @(negedge clk); rst_n = 1'b1;
        act = 0;
        repeat (10) begin @(posedge clk); #1; if (!cs_n || busy) act++; end
        checks++; if (act != 0) begin fails++; $display("FAIL midframe_no_restart: got %0d active cycles want 0", act); end
        @(negedge clk); tr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int falls;
        logic pcs;
        run_frame(8'h04, 32'hCAFE_F00D, 32, 1'b0, 1'b1, "retrig");
        falls = 0; pcs = cs_n;
        repeat (80) begin @(posedge clk); #1; if (!cs_n && pcs) falls++; pcs = cs_n; end
        checks++; if (falls != 0) begin fails++; $display("FAIL retrig_extra_frame: got %0d frames want 0", falls); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide_mutate();
        test_sequence();
        test_error();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ad9911_serial_tx.md
AD9911_SERIAL_TX -- requirements
Module: ad9911_serial_tx

Interface
REQ-001 Parameter CLK_DIV, default 2, means the SCLK half-period in CLK cycles; legal values are 1 and above.
REQ-002 Parameter UPD_WIDTH, default 4, means the IO_UPDATE pulse width in CLK cycles; 0 disables the pulse.
REQ-003 CLK  input  1  system clock; all logic on its rising edge.
REQ-004 RESET_N  input  1  reset, synchronous, active-low.
REQ-005 TR  input  1  transfer request; its 0->1 edge starts one register write.
REQ-006 ADDR  input  8  AD9911 register address; sampled on the accepting edge.
REQ-007 DATA  input  32  register value, right-aligned; sampled on the accepting edge.
REQ-008 OVER  output  1  done level; cleared on the accepting edge, set at completion, then held until the next accept.
REQ-009 ERR  output  1  last request had an illegal address; cleared on the next accept.
REQ-010 BUSY  output  1  high in any state other than IDLE.
REQ-011 CS_N  output  1  AD9911 chip select, active-low.
REQ-012 SCLK  output  1  serial clock, idle low.
REQ-013 SDIO  output  1  serial data, MSB first; changes only while SCLK is low.
REQ-014 IO_UPDATE  output  1  AD9911 IO_UPDATE pulse.

Function
REQ-015 The block SHALL register TR each cycle as TR_d; an accept occurs only in IDLE when TR=1 and TR_d=0, and a rising edge outside IDLE is ignored, with no queueing.
REQ-016 On accept (edge e0), the block SHALL latch ADDR/DATA, clear OVER and ERR, and select payload width W from ADDR.
- 0x00 -> 8
- 0x02, 0x05, 0x07 -> 16
- 0x01, 0x03, 0x06 -> 24
- 0x04, 0x08-0x18 -> 32
REQ-017 The shifted frame SHALL be an instruction byte {1'b0, 2'b00, ADDR[4:0]} followed by DATA[W-1:0] MSB first, giving N=8+W bits.
REQ-018 If ADDR>0x18, the block SHALL skip all pin activity and set OVER=1 and ERR=1 at e0+1.
REQ-019 The state sequence SHALL be IDLE -> SETUP -> SHIFT -> HOLD -> UPDATE -> IDLE.
- UPDATE is skipped when UPD_WIDTH=0.
- The ERR path goes IDLE -> ERRDONE -> IDLE.
REQ-020 Timing with H=CLK_DIV:
- CS_N falls at e0 and SDIO shows bit N-1.
- SCLK bit i rises at e0+H+2H*i and falls at e0+2H+2H*i.
- SDIO updates to the next bit on each falling edge.
REQ-021 HOLD timing: after the last falling edge (e0+2HN), CS_N SHALL stay low H cycles and rise at e0+(2N+1)H, with SDIO returning to 0.
REQ-022 IO_UPDATE SHALL be high from e0+(2N+1)H for exactly UPD_WIDTH cycles.
REQ-023 OVER SHALL rise at e0+(2N+1)H+UPD_WIDTH, at the same edge where BUSY falls.
REQ-024 With default parameters, OVER SHALL rise at e0+70 (N=16), e0+102 (N=24), e0+134 (N=32), and e0+166 (N=40).
REQ-025 A compatible initiator holds TR high for at least 1 cycle and may drop TR at any time; OVER SHALL be low by e0, so an initiator checking OVER two cycles after raising TR sees it low.
REQ-026 ADDR/DATA changes after e0 SHALL NOT affect the frame in flight.

Reset
REQ-027 While RESET_N=0, the block SHALL drive these values, regardless of state (including mid-frame):
- state IDLE
- CS_N=1, SCLK=0, SDIO=0, IO_UPDATE=0
- OVER=0, ERR=0, BUSY=0
REQ-028 TR_d SHALL reset to 1, so a TR held high through reset starts no transfer until it goes low then high again.

Structure
REQ-029 Shared package ad9911_pkg SHALL hold the state encoding, the instruction-byte constant, the address-to-width table, and the 0x18 maximum-address constant.
REQ-030 The block SHALL be a single flat module with no sub-module; the half-period tick counter and bit counter are internal.

Verification
REQ-031 Accept ADDR=0x00, DATA=0x20 -> 16 SCLK pulses; SDIO sequence 0x00 then 0x20; CS_N low from e0 to e0+66; IO_UPDATE high e0+66..e0+69; OVER rises at e0+70.
REQ-032 Accept ADDR=0x04, DATA=0x0111_1111 -> 40 bits 0x04,0x01,0x11,0x11,0x11; OVER at e0+166; DATA changed at e0+3 leaves the frame unchanged.
REQ-033 Drive the 11-register sequence 0x00..0x0A with the initiator protocol (TR high 2 cycles, wait OVER) -> 11 frames with widths 8,24,16,24,32,16,24,16,32,32,32; no frame is lost or duplicated.
REQ-034 Accept ADDR=0x1F -> no CS_N, SCLK or IO_UPDATE activity; OVER=1 and ERR=1 at e0+1; a following legal request clears ERR at its e0.
REQ-035 Assert RESET_N=0 at e0+40 of a 40-bit frame with TR held high -> all outputs at reset values next edge; no new frame until TR goes low then high.
REQ-036 Raise a second TR edge at e0+50 -> ignored; exactly one frame is sent.
